// File: rtl/loader_stream_tx_if.sv
// Bundle of the loader transmit signals: command, upstream word stream and control_plane side.
// The slave modport is the transmitter's view and the master modport is the driver's view.
interface loader_stream_tx_if #(
    parameter int PHIT_W = 512,
    parameter int CNT_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  num_state;
    logic [CNT_W+2:0]  num_config;
    logic [CNT_W-1:0]  num_inbound;

    logic [PHIT_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    logic              start_loader;
    logic [PHIT_W-1:0] wr_data;
    logic              wr_valid;
    logic              start_stream_in;
    logic              stream_ack;
    logic              busy;
    logic              err;

    modport slave (
        input  cmd_valid, num_state, num_config, num_inbound,
        input  s_data, s_valid, stream_ack,
        output cmd_ready, s_ready, start_loader, wr_data, wr_valid,
        output start_stream_in, busy, err
    );

    modport master (
        output cmd_valid, num_state, num_config, num_inbound,
        output s_data, s_valid, stream_ack,
        input  cmd_ready, s_ready, start_loader, wr_data, wr_valid,
        input  start_stream_in, busy, err
    );
endinterface

// File: rtl/loader_stream_tx.sv
// Loader transmit side: buffers a complete table image from upstream, then pulses start_loader
// and replays the image as one gap-free registered burst, since the loader cannot backpressure.
module loader_stream_tx #(
    parameter int PHIT_W     = 512,
    parameter int CNT_W      = 6,
    parameter int FIFO_DEPTH = 64,
    parameter int GAP_CYC    = 2
) (
    input  logic              clk,
    input  logic              rst,
    loader_stream_tx_if.slave bus
);
    localparam int TOT_W = CNT_W + 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [TOT_W-1:0] DEPTH_T  = TOT_W'(FIFO_DEPTH);
    localparam logic [TOT_W-1:0] GAP_LAST = TOT_W'(GAP_CYC - 1);
    localparam logic [TOT_W-1:0] CNT_ONE  = TOT_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PULSE,
        ST_GAP,
        ST_STREAM,
        ST_ARM
    } state_e;

    state_e            state_q, state_d;

    logic [TOT_W-1:0]  cmd_total;
    logic              cmd_ok;
    logic              cmd_hs;
    logic              s_hs;
    logic              last_word;
    logic              gap_done;
    logic              last_phit;
    logic              pop;
    logic              fifo_empty;

    logic [TOT_W-1:0]  total_q, total_d;
    logic [TOT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [PHIT_W-1:0] wr_data_q, wr_data_d;
    logic              wr_valid_q, wr_valid_d;
    logic              err_q, err_d;

    logic [PHIT_W-1:0] mem [FIFO_DEPTH];

    // Totals are widened before adding so three maximal counts cannot wrap.
    assign cmd_total = TOT_W'(bus.num_state) + TOT_W'(bus.num_config) + TOT_W'(bus.num_inbound);
    assign cmd_ok    = (cmd_total != '0) && (cmd_total <= DEPTH_T);
    assign cmd_hs    = bus.cmd_valid && bus.cmd_ready;
    assign s_hs      = bus.s_valid && bus.s_ready;

    // cnt_q restarts at every state change: words accepted in FILL, cycles in GAP,
    // index of the phit currently on wr_data in STREAM.
    assign last_word  = s_hs && (cnt_q == total_q - CNT_ONE);
    assign gap_done   = (cnt_q == GAP_LAST);
    assign last_phit  = (cnt_q == total_q - CNT_ONE);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cmd_hs && cmd_ok) state_d = ST_FILL;
            ST_FILL:   if (last_word) state_d = ST_PULSE;
            ST_PULSE:  state_d = (GAP_CYC == 0) ? ST_STREAM : ST_GAP;
            ST_GAP:    if (gap_done) state_d = ST_STREAM;
            ST_STREAM: if (last_phit) state_d = ST_ARM;
            ST_ARM:    if (bus.stream_ack) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // cmd_ready is gated by the reset pin so every output reads 0 while reset is held.
    always_comb begin
        bus.cmd_ready       = 1'b0;
        bus.s_ready         = 1'b0;
        bus.start_loader    = 1'b0;
        bus.start_stream_in = 1'b0;
        unique case (state_q)
            ST_IDLE:  bus.cmd_ready       = rst;
            ST_FILL:  bus.s_ready         = (cnt_q < total_q);
            ST_PULSE: bus.start_loader    = 1'b1;
            ST_ARM:   bus.start_stream_in = 1'b1;
            default:  ;
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);

    always_comb begin
        total_d  = total_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (cmd_hs) begin
            err_d = !cmd_ok;
            if (cmd_ok) total_d = cmd_total;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (s_hs || state_q == ST_GAP || state_q == ST_STREAM) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (s_hs) wr_ptr_d = wr_ptr_q + PTR_ONE;

        // Loading on the transition into STREAM keeps wr_data registered with no leading bubble.
        pop        = (state_d == ST_STREAM);
        wr_valid_d = pop;
        wr_data_d  = pop ? mem[rd_ptr_q[PTR_W-1:0]] : '0;
        if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q    <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            total_q    <= total_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the image buffer has no reset; pointers define validity and stale entries are never read.
    always_ff @(posedge clk) begin
        if (s_hs) mem[wr_ptr_q[PTR_W-1:0]] <= bus.s_data;
    end

    assign bus.wr_data  = wr_data_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.err      = err_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst) pop |-> !fifo_empty);

endmodule

// File: tb/tb_loader_stream_tx.sv
// Self-checking bench for loader_stream_tx: directed command sequence with random image data
// and stalls, compared against a queue-based model of image order and burst timing.
module tb_loader_stream_tx;
    localparam int PHIT_W     = 512;
    localparam int CNT_W      = 6;
    localparam int CFG_W      = CNT_W + 3;
    localparam int FIFO_DEPTH = 64;
    localparam int GAP_CYC    = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    loader_stream_tx_if #(.PHIT_W(PHIT_W), .CNT_W(CNT_W)) bus ();

    loader_stream_tx #(
        .PHIT_W(PHIT_W), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [PHIT_W-1:0] obs, input logic [PHIT_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PHIT_W-1:0] rand_word();
        logic [PHIT_W-1:0] w;
        for (int i = 0; i < PHIT_W / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    // Called at a negedge; returns at the following negedge with the command presented once.
    task automatic send_cmd(input int ns, input int nc, input int ni, input logic exp_ready);
        bus.num_state   = CNT_W'(ns);
        bus.num_config  = CFG_W'(nc);
        bus.num_inbound = CNT_W'(ni);
        bus.cmd_valid   = 1'b1;
        checkb("cmd_ready", bus.cmd_ready, exp_ready);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic bad_cmd(input int ns, input int nc, input int ni);
        send_cmd(ns, nc, ni, 1'b1);
        checkb("bad_err", bus.err, 1'b1);
        checkb("bad_busy", bus.busy, 1'b0);
        checkb("bad_cmd_ready", bus.cmd_ready, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkb("bad_no_pulse", bus.start_loader, 1'b0);
            checkb("bad_idle", bus.busy, 1'b0);
            checkb("bad_err_sticky", bus.err, 1'b1);
        end
    endtask

    // One complete load: command, fill with optional stalls, pulse, gap, burst, ARM and ack.
    // abort_at >= 0 asserts reset while that phit index is on wr_data.
    task automatic do_image(input int ns, input int nc, input int ni, input int stall_pct,
                            input int ack_delay, input int abort_at, input bit seq_data,
                            input bit chain);
        logic [PHIT_W-1:0] img[$];
        int   total;
        int   idx;
        int   rdy_cycles;
        int   budget;
        logic v;

        total      = ns + nc + ni;
        idx        = 0;
        rdy_cycles = 0;
        budget     = 0;
        for (int i = 0; i < total; i++) img.push_back(seq_data ? PHIT_W'(i) : rand_word());

        send_cmd(ns, nc, ni, 1'b1);
        checkb("err_clear", bus.err, 1'b0);
        checkb("busy_fill", bus.busy, 1'b1);

        while (idx < total && budget < 40 * total + 100) begin
            v = ($urandom_range(99) >= stall_pct);
            checkb("s_ready_fill", bus.s_ready, 1'b1);
            if (bus.s_ready) rdy_cycles++;
            bus.s_valid = v;
            bus.s_data  = v ? img[idx] : rand_word();
            @(negedge clk);
            if (v) idx++;
            budget++;
        end
        checkb("fill_done", idx == total, 1'b1);
        if (stall_pct == 0) checkb("ready_cycles", rdy_cycles == total, 1'b1);

        // Junk upstream traffic and a spurious ack must both be ignored from here on.
        bus.s_valid    = 1'b1;
        bus.s_data     = rand_word();
        bus.stream_ack = 1'b1;
        checkb("pulse", bus.start_loader, 1'b1);
        checkb("pulse_s_ready", bus.s_ready, 1'b0);
        checkb("pulse_wr_valid", bus.wr_valid, 1'b0);

        for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge clk);
            checkb("gap_pulse_low", bus.start_loader, 1'b0);
            checkb("gap_wr_valid", bus.wr_valid, 1'b0);
            checkw("gap_wr_data", bus.wr_data, '0);
            checkb("gap_s_ready", bus.s_ready, 1'b0);
        end
        bus.stream_ack = 1'b0;

        for (int p = 0; p < total; p++) begin
            @(negedge clk);
            checkb("phit_valid", bus.wr_valid, 1'b1);
            checkw("phit_data", bus.wr_data, img[p]);
            checkb("stream_s_ready", bus.s_ready, 1'b0);
            checkb("stream_cmd_ready", bus.cmd_ready, 1'b0);
            checkb("stream_si", bus.start_stream_in, 1'b0);
            if (p == abort_at) begin
                rst         = 1'b0;
                bus.s_valid = 1'b0;
                #1;
                checkb("rst_wr_valid", bus.wr_valid, 1'b0);
                checkw("rst_wr_data", bus.wr_data, '0);
                checkb("rst_busy", bus.busy, 1'b0);
                checkb("rst_cmd_ready", bus.cmd_ready, 1'b0);
                checkb("rst_s_ready", bus.s_ready, 1'b0);
                checkb("rst_pulse", bus.start_loader, 1'b0);
                checkb("rst_si", bus.start_stream_in, 1'b0);
                checkb("rst_err", bus.err, 1'b0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                checkb("post_rst_ready", bus.cmd_ready, 1'b1);
                checkb("post_rst_wr_valid", bus.wr_valid, 1'b0);
                return;
            end
        end

        @(negedge clk);
        bus.s_valid = 1'b0;
        checkb("end_wr_valid", bus.wr_valid, 1'b0);
        checkw("end_wr_data", bus.wr_data, '0);
        if (chain) begin
            bus.num_state   = CNT_W'(ns);
            bus.num_config  = CFG_W'(nc);
            bus.num_inbound = CNT_W'(ni);
            bus.cmd_valid   = 1'b1;
        end

        for (int d = 0; d < ack_delay; d++) begin
            checkb("arm_si", bus.start_stream_in, 1'b1);
            checkb("arm_cmd_ready", bus.cmd_ready, 1'b0);
            checkb("arm_busy", bus.busy, 1'b1);
            @(negedge clk);
        end
        checkb("arm_si_at_ack", bus.start_stream_in, 1'b1);
        bus.stream_ack = 1'b1;
        @(negedge clk);
        bus.stream_ack = 1'b0;
        checkb("ack_si_low", bus.start_stream_in, 1'b0);
        checkb("ack_idle", bus.busy, 1'b0);
        checkb("ack_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.num_state   = '0;
        bus.num_config  = '0;
        bus.num_inbound = '0;
        bus.s_data      = '0;
        bus.s_valid     = 1'b0;
        bus.stream_ack  = 1'b0;

        @(negedge clk);
        checkb("reset_cmd_ready", bus.cmd_ready, 1'b0);
        checkb("reset_busy", bus.busy, 1'b0);
        checkb("reset_err", bus.err, 1'b0);
        checkb("reset_wr_valid", bus.wr_valid, 1'b0);
        checkw("reset_wr_data", bus.wr_data, '0);
        checkb("reset_si", bus.start_stream_in, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkb("idle_cmd_ready", bus.cmd_ready, 1'b1);
        checkb("idle_s_ready", bus.s_ready, 1'b0);

        // FIR image, words 0..29, no stalls
        do_image(2, 12, 16, 0, 3, -1, 1'b1, 1'b0);
        // same shape with ~50% upstream stalls and random data
        do_image(2, 12, 16, 50, 1, -1, 1'b0, 1'b0);

        // oversized, empty and maximal (non-wrapping) totals are rejected
        bad_cmd(20, 25, 20);
        do_image(1, 0, 0, 0, 1, -1, 1'b0, 1'b0);
        bad_cmd(0, 0, 0);
        do_image(0, 0, 1, 30, 2, -1, 1'b0, 1'b0);
        bad_cmd(63, 511, 63);
        bad_cmd(0, 65, 0);
        // exactly FIFO_DEPTH is accepted
        do_image(0, 64, 0, 20, 1, -1, 1'b0, 1'b0);

        // reset at the 10th phit, then a fresh small image
        do_image(4, 10, 6, 30, 1, 9, 1'b0, 1'b0);
        do_image(2, 1, 1, 0, 1, -1, 1'b0, 1'b0);

        // back-to-back 40-word images; the second crosses the pointer wrap
        do_image(10, 20, 10, 20, 2, -1, 1'b0, 1'b1);
        do_image(10, 20, 10, 20, 2, -1, 1'b0, 1'b0);

        // late acknowledge
        do_image(3, 3, 3, 0, 20, -1, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
